// File: rtl/mac_pkg.sv
// Shared types and defaults for the multiply-accumulate sequencer.
package mac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StBusy,
    StAcc,
    StOut
  } state_e;

  localparam int unsigned DefW    = 4;
  localparam int unsigned DefAccW = 12;

  // The accumulator must hold at least one full-width product.
  function automatic bit acc_w_ok(input int unsigned w, input int unsigned acc_w);
    return acc_w >= 2 * w;
  endfunction

  localparam bit DefWidthOk = acc_w_ok(DefW, DefAccW);

endpackage

// File: rtl/mac_acc.sv
// Wide accumulator with carry-out detection and a sticky overflow bit.
module mac_acc #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_en,
  input  logic              clr,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] sum_ext;

  // Extra top bit of the add is the carry out of the accumulator
  always_comb begin
    sum_ext = {1'b0, sum} + (ACC_W+1)'(prod);
  end

  // Clear wins over add; overflow only ever sets until cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      sum <= sum_ext[ACC_W-1:0];
      ovf <= ovf | sum_ext[ACC_W];
    end
  end

endmodule

// File: rtl/mul.sv
// Shared-clock sequential shift-add multiplier. `done` is a registered level that
// drops when a start is taken and rises with the final product; starts are ignored
// while computing.
module mul #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   m,
  input  logic [W-1:0]   r,
  output logic [2*W-1:0] prod,
  output logic           done
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic            busy;
  logic [CntW-1:0] cnt;
  logic [2*W-1:0]  mcand;
  logic [W-1:0]    mplier;

  // One partial product per cycle, W cycles per multiply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      prod   <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (!busy) begin
      if (start) begin
        busy   <= 1'b1;
        done   <= 1'b0;
        prod   <= '0;
        cnt    <= '0;
        mcand  <= (2*W)'(m);
        mplier <= r;
      end
    end else begin
      if (mplier[0]) begin
        prod <= prod + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CntW'(W - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_ctrl.sv
// Multiply-accumulate sequencer: feeds operand pairs to `mul`, accumulates the
// products and presents the sum when the pair tagged last completes.
module mac_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_m,
  input  logic [W-1:0]     in_r,
  input  logic             in_last,
  output logic [W-1:0]     mul_m,
  output logic [W-1:0]     mul_r,
  output logic             mul_start,
  input  logic [2*W-1:0]   mul_prod,
  input  logic             mul_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  if (!acc_w_ok(W, ACC_W)) begin : g_width_check
    $error("mac_ctrl: ACC_W must be at least 2*W");
  end

  state_e state;
  logic   last_q;
  logic   add_en;
  logic   clr;

  // Accumulator strobes decoded from the current state
  always_comb begin
    add_en = (state == StAcc);
    clr    = (state == StOut) && out_ready;
  end

  // Sequencer with registered handshake outputs and operand latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b0;
      mul_start <= 1'b0;
      mul_m     <= '0;
      mul_r     <= '0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            mul_m     <= in_m;
            mul_r     <= in_r;
            last_q    <= in_last;
            in_ready  <= 1'b0;
            mul_start <= 1'b1;
            state     <= StIssue;
          end else begin
            in_ready <= 1'b1;
          end
        end
        // Hold start until the multiplier shows it has left its done state
        StIssue: begin
          if (!mul_done) begin
            mul_start <= 1'b0;
            state     <= StBusy;
          end
        end
        StBusy: begin
          if (mul_done) begin
            state <= StAcc;
          end
        end
        StAcc: begin
          if (last_q) begin
            out_valid <= 1'b1;
            state     <= StOut;
          end else begin
            in_ready <= 1'b1;
            state    <= StIdle;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  mac_acc #(
    .PROD_W(2 * W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .add_en(add_en),
    .clr   (clr),
    .prod  (mul_prod),
    .sum   (out_acc),
    .ovf   (out_ovf)
  );

endmodule

// File: tb/tb_mac_ctrl.sv
// Self-checking bench for mac_ctrl driving the real sequential multiplier.
module tb_mac_ctrl;

  localparam int unsigned W     = 4;
  localparam int unsigned ACC_W = 12;
  localparam int unsigned Mod   = 1 << ACC_W;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_m;
  logic [W-1:0]     in_r;
  logic             in_last;
  logic [W-1:0]     mul_m;
  logic [W-1:0]     mul_r;
  logic             mul_start;
  logic [2*W-1:0]   mul_prod;
  logic             mul_done;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  int checks;
  int failures;
  // Reference: unbounded running sum of the accepted products of the current dot product
  int unsigned total;

  mac_ctrl #(
    .W    (W),
    .ACC_W(ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_m     (in_m),
    .in_r     (in_r),
    .in_last  (in_last),
    .mul_m    (mul_m),
    .mul_r    (mul_r),
    .mul_start(mul_start),
    .mul_prod (mul_prod),
    .mul_done (mul_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_ovf  (out_ovf)
  );

  mul #(
    .W(W)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .m    (mul_m),
    .r    (mul_r),
    .prod (mul_prod),
    .done (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_acc();
    return total % Mod;
  endfunction

  function automatic logic [31:0] exp_ovf();
    return (total >= Mod) ? 32'd1 : 32'd0;
  endfunction

  // Offer one pair, confirm the accept edge, optionally wait for the multiply to finish
  task automatic send(input logic [W-1:0] m, input logic [W-1:0] r, input logic last,
                      input bit junk, input bit wait_done);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_m     = m;
    in_r     = r;
    in_last  = last;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("accept_ready", in_ready, 1);
    check("start_pre", mul_start, 0);
    tick();
    total += int'(m) * int'(r);
    check("start_lat", mul_start, 1);
    check("ready_drop", in_ready, 0);
    check("mul_m", mul_m, m);
    check("mul_r", mul_r, r);
    if (junk) begin
      in_m    = W'($urandom);
      in_r    = W'($urandom);
      in_last = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    if (wait_done) begin
      n = 0;
      while (!(mul_done && !mul_start) && n < 100) begin
        tick();
        n++;
        if (junk) begin
          in_m    = W'($urandom);
          in_r    = W'($urandom);
          in_last = 1'($urandom);
        end
      end
      check("ready_in_mul", in_ready, 0);
      n = 0;
      while (!in_ready && !out_valid && n < 100) begin
        tick();
        n++;
        if (junk) begin
          in_m    = W'($urandom);
          in_r    = W'($urandom);
          in_last = 1'($urandom);
        end
      end
      in_valid = 1'b0;
      check("pair_done", in_ready | out_valid, 1);
    end
  endtask

  // Wait for the result, hold it back for `hold` cycles, then take it
  task automatic get_result(input int hold);
    int n;
    n = 0;
    if (hold > 0) out_ready = 1'b0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("out_valid_wait", out_valid, 1);
    check("out_acc", out_acc, exp_acc());
    check("out_ovf", out_ovf, exp_ovf());
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_acc", out_acc, exp_acc());
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("out_pulse", out_valid, 0);
    check("ready_after_out", in_ready, 1);
    total = 0;
  endtask

  initial begin
    int n;
    int len;
    logic [W-1:0] a;
    logic [W-1:0] b;
    checks    = 0;
    failures  = 0;
    total     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_m      = '0;
    in_r      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_m", mul_m, 0);
    check("rst_mul_r", mul_r, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;
    check("rel_in_ready", in_ready, 0);
    tick();
    check("rel_in_ready_edge", in_ready, 1);

    // Single pair with the last flag
    out_ready = 1'b1;
    send(4'd5, 4'd6, 1'b1, 1'b0, 1'b1);
    get_result(0);

    // Three-pair dot product
    send(4'd5, 4'd6, 1'b0, 1'b0, 1'b1);
    send(4'd3, 4'd7, 1'b0, 1'b0, 1'b1);
    send(4'd15, 4'd15, 1'b1, 1'b0, 1'b1);
    get_result(0);

    // Overflow, then a fresh single product clears it
    for (int i = 0; i < 19; i++) begin
      send(4'd15, 4'd15, (i == 18), 1'b0, 1'b1);
    end
    get_result(0);
    send(4'd1, 4'd1, 1'b1, 1'b0, 1'b1);
    get_result(0);

    // Result back-pressure; next pair follows straight after the handshake
    send(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b1);
    send(W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b1);
    get_result(5);
    send(4'd9, 4'd2, 1'b1, 1'b0, 1'b1);
    get_result(0);

    // Valid held high with changing data while busy
    for (int i = 0; i < 4; i++) begin
      send(W'($urandom), W'($urandom), (i == 3), 1'b1, 1'b1);
    end
    get_result(0);

    // Random dot products
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        a = W'($urandom);
        b = W'($urandom);
        send(a, b, (i == len - 1), 1'($urandom), 1'b1);
      end
      get_result($urandom_range(0, 3));
    end

    // Reset while the second pair is multiplying
    send(4'd7, 4'd9, 1'b0, 1'b0, 1'b1);
    send(4'd4, 4'd5, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (mul_start && n < 100) begin
      tick();
      n++;
    end
    check("busy_reached", mul_start, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_mul_start", mul_start, 0);
    check("mid_rst_mul_m", mul_m, 0);
    check("mid_rst_mul_r", mul_r, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_acc", out_acc, 0);
    check("mid_rst_out_ovf", out_ovf, 0);
    tick();
    tick();
    rst   = 1'b0;
    total = 0;
    tick();
    check("post_rst_ready", in_ready, 1);
    send(4'd2, 4'd3, 1'b1, 1'b0, 1'b1);
    get_result(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
